simon_key_schedule: RTL

- Iterative SIMON32/64 key expansion engine.
- Accepts one 64-bit master key, then streams 16-bit round keys k0..k(ROUNDS-1) one per handshake.
- Output feeds the round_key input of the combinational round stage; the cipher datapath consumes one round key per round.
- Sits directly upstream of the round stage, alongside the round-iteration controller.

---
 rtl/simon_key_schedule.sv | 123 ++++++++++++
 1 files changed

// File: rtl/simon_key_schedule.sv
// simon_key_schedule
//   Iterative SIMON32/64 key expansion. Accepts one 64-bit master key and
//   streams ROUNDS 16-bit round keys k0..k(ROUNDS-1), one per rk handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   key_valid  master key offered
//   key_ready  master key can be accepted (IDLE only)
//   key[63:0]  master key {k3, k2, k1, k0}
//   rk_valid   round_key/round_idx/rk_last are valid
//   rk_ready   consumer takes the current round key
//   round_key  current round key k[i]
//   round_idx  index i of the current round key
//   rk_last    i == ROUNDS-1
module simon_key_schedule #(
  parameter int unsigned ROUNDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [15:0] round_key,
  output logic [4:0]  round_idx,
  output logic        rk_last
);

  typedef enum logic {IDLE, RUN} state_t;

  // z0 sequence with element j at bit j; padded to 64 bits so the 6-bit
  // pointer never selects outside the vector.
  localparam logic [63:0] Z0 = {2'b00,
    62'b0110011100001101010010001011111_0110011100001101010010001011111};
  localparam logic [6:0]  LAST = 7'(ROUNDS - 1);

  state_t      state_q, state_d;
  logic [15:0] w0_q, w1_q, w2_q, w3_q;
  logic [15:0] w0_d, w1_d, w2_d, w3_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [5:0]  zptr_q, zptr_d;

  logic [15:0] t1, t2, knew;
  logic        run, xfer, last;

  // Next window word; zptr tracks (index of knew - 4) mod 62.
  always_comb begin
    t1   = {w3_q[2:0], w3_q[15:3]} ^ w1_q;
    t2   = t1 ^ {t1[0], t1[15:1]};
    knew = ~w0_q ^ t2 ^ 16'h0003 ^ {15'b0, Z0[zptr_q]};
  end

  assign run  = (state_q == RUN);
  assign last = (cnt_q == LAST);
  assign xfer = run && rk_ready;

  assign key_ready = (state_q == IDLE);
  assign rk_valid  = run;
  assign round_key = run ? w0_q : '0;
  assign round_idx = run ? cnt_q[4:0] : '0;
  assign rk_last   = run && last;

  always_comb begin
    state_d = state_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    w3_d    = w3_q;
    cnt_d   = cnt_q;
    zptr_d  = zptr_q;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          w0_d    = key[15:0];
          w1_d    = key[31:16];
          w2_d    = key[47:32];
          w3_d    = key[63:48];
          cnt_d   = '0;
          zptr_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            w0_d   = w1_q;
            w1_d   = w2_q;
            w2_d   = w3_q;
            w3_d   = knew;
            cnt_d  = cnt_q + 7'd1;
            zptr_d = (zptr_q == 6'd61) ? '0 : zptr_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      cnt_q   <= '0;
      zptr_q  <= '0;
    end else begin
      state_q <= state_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
      cnt_q   <= cnt_d;
      zptr_q  <= zptr_d;
    end
  end

endmodule
